// File: rtl/ball_pkg.sv
// Shared definitions for the ball game engine: FSM encoding, direction
// constants and the serve-position helper.
package ball_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_OVER  = 3'd2,
        ST_UPD   = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

    localparam logic [1:0] OST_IDLE = 2'd0;
    localparam logic [1:0] OST_RUN  = 2'd1;
    localparam logic [1:0] OST_OVER = 2'd2;

    localparam logic DIR_X_RIGHT = 1'b1;
    localparam logic DIR_X_LEFT  = 1'b0;
    localparam logic DIR_Y_DOWN  = 1'b1;
    localparam logic DIR_Y_UP    = 1'b0;

    // Balls are spread evenly across the middle half of the screen.
    function automatic int serve_x(input int h_act, input int n_ball, input int idx);
        return h_act / 4 + idx * (h_act / (2 * n_ball));
    endfunction

endpackage

// File: rtl/ball_step.sv
// Combinational one-frame advance of a single ball: wall bounce, paddle
// bounce and floor miss. Shared by all balls through the top's index.
module ball_step
    import ball_pkg::*;
#(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int POS_W = 11,
    parameter int SPD_W = 4,
    parameter int R_W   = 4
) (
    input  logic [POS_W-1:0] i_x,
    input  logic [POS_W-1:0] i_y,
    input  logic             i_dx,
    input  logic             i_dy,
    input  logic [SPD_W-1:0] i_sx,
    input  logic [SPD_W-1:0] i_sy,
    input  logic [R_W-1:0]   i_r,
    input  logic [POS_W-1:0] i_pad_x1,
    input  logic [POS_W-1:0] i_pad_x2,
    input  logic [POS_W-1:0] i_pad_y,
    output logic [POS_W-1:0] o_x,
    output logic [POS_W-1:0] o_y,
    output logic             o_dx,
    output logic             o_dy,
    output logic             o_hit,
    output logic             o_miss
);
    localparam int W = POS_W + 1;

    logic [W-1:0] w_x, w_y, w_sx, w_sy, w_r, w_py, w_px1, w_px2, w_xn;

    assign w_x   = W'(i_x);
    assign w_y   = W'(i_y);
    assign w_sx  = W'(i_sx);
    assign w_sy  = W'(i_sy);
    assign w_r   = W'(i_r);
    assign w_py  = W'(i_pad_y);
    assign w_px1 = W'(i_pad_x1);
    assign w_px2 = W'(i_pad_x2);
    assign w_xn  = W'(o_x);

    // Horizontal axis: side-wall bounce, zero speed freezes the axis.
    always_comb begin
        o_x  = i_x;
        o_dx = i_dx;
        if (i_sx == '0) begin
            o_x = i_x;
        end else if (i_dx == DIR_X_RIGHT) begin
            if (w_x + w_sx + w_r >= W'(H_ACT - 1)) begin
                o_x  = POS_W'(W'(H_ACT - 1) - w_r);
                o_dx = DIR_X_LEFT;
            end else begin
                o_x = POS_W'(w_x + w_sx);
            end
        end else begin
            if (w_x < w_sx + w_r) begin
                o_x  = POS_W'(w_r);
                o_dx = DIR_X_RIGHT;
            end else begin
                o_x = POS_W'(w_x - w_sx);
            end
        end
    end

    // Vertical axis: ceiling bounce, paddle hit against the new x, floor miss.
    always_comb begin
        o_y    = i_y;
        o_dy   = i_dy;
        o_hit  = 1'b0;
        o_miss = 1'b0;
        if (i_sy == '0) begin
            o_y = i_y;
        end else if (i_dy == DIR_Y_UP) begin
            if (w_y < w_sy + w_r) begin
                o_y  = POS_W'(w_r);
                o_dy = DIR_Y_DOWN;
            end else begin
                o_y = POS_W'(w_y - w_sy);
            end
        end else if ((w_y + w_r < w_py) && (w_y + w_sy + w_r >= w_py) &&
                     (w_px1 <= w_xn) && (w_xn <= w_px2)) begin
            o_y   = POS_W'(w_py - w_r - W'(1));
            o_dy  = DIR_Y_UP;
            o_hit = 1'b1;
        end else if (w_y + w_sy + w_r >= W'(V_ACT - 1)) begin
            o_miss = 1'b1;
        end else begin
            o_y = POS_W'(w_y + w_sy);
        end
    end

endmodule

// File: rtl/ball_engine.sv
// Multi-ball physics and game-state engine: one shared step unit walks the
// balls once per frame, then lives/serve are resolved in a check cycle.
module ball_engine
    import ball_pkg::*;
#(
    parameter int N_BALL = 2,
    parameter int H_ACT  = 640,
    parameter int V_ACT  = 480,
    parameter int POS_W  = 11,
    parameter int SPD_W  = 4,
    parameter int R_W    = 4,
    parameter int LIVES  = 3
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iFRAME,
    input  logic                    iSTART,
    input  logic [SPD_W-1:0]        iSPEED_X,
    input  logic [SPD_W-1:0]        iSPEED_Y,
    input  logic [R_W-1:0]          iRADIUS,
    input  logic [POS_W-1:0]        iPAD_X1,
    input  logic [POS_W-1:0]        iPAD_X2,
    input  logic [POS_W-1:0]        iPAD_Y,
    output logic [N_BALL*POS_W-1:0] oBALL_X,
    output logic [N_BALL*POS_W-1:0] oBALL_Y,
    output logic [N_BALL-1:0]       oBALL_ACT,
    output logic [1:0]              oSTATE,
    output logic [15:0]             oSCORE,
    output logic [2:0]              oLIVES,
    output logic                    oHIT,
    output logic                    oMISS,
    output logic                    oBUSY
);
    localparam int IDX_W = (N_BALL > 1) ? $clog2(N_BALL) : 1;

    state_t             r_state, w_state_nxt;
    logic [POS_W-1:0]   r_x [N_BALL];
    logic [POS_W-1:0]   r_y [N_BALL];
    logic [N_BALL-1:0]  r_dx, r_dy, r_act;
    logic [IDX_W-1:0]   r_idx;
    logic [SPD_W-1:0]   r_sx, r_sy;
    logic [R_W-1:0]     r_r;
    logic [15:0]        r_score;
    logic [2:0]         r_lives;
    logic               r_hit, r_miss, r_busy;
    logic [1:0]         r_ostate, w_ostate_nxt;
    logic               w_busy_nxt, w_serve, w_last, w_upd_act;
    logic [POS_W-1:0]   w_serve_x [N_BALL];
    logic [N_BALL-1:0]  w_serve_dx;
    logic [POS_W-1:0]   w_x, w_y;
    logic               w_dx, w_dy, w_hit, w_miss;

    for (genvar g = 0; g < N_BALL; g++) begin : g_serve
        assign w_serve_x[g]  = POS_W'(serve_x(H_ACT, N_BALL, g));
        assign w_serve_dx[g] = (g % 2 == 0) ? DIR_X_RIGHT : DIR_X_LEFT;
        assign oBALL_X[g*POS_W +: POS_W] = r_x[g];
        assign oBALL_Y[g*POS_W +: POS_W] = r_y[g];
    end

    assign w_last    = (r_idx == IDX_W'(N_BALL - 1));
    assign w_upd_act = (r_state == ST_UPD) && r_act[r_idx];
    assign w_serve   = ((r_state == ST_IDLE) && iSTART) ||
                       ((r_state == ST_CHECK) && (r_act == '0) && (r_lives > 3'd1));

    ball_step #(
        .H_ACT(H_ACT), .V_ACT(V_ACT), .POS_W(POS_W), .SPD_W(SPD_W), .R_W(R_W)
    ) u_step (
        .i_x(r_x[r_idx]), .i_y(r_y[r_idx]), .i_dx(r_dx[r_idx]), .i_dy(r_dy[r_idx]),
        .i_sx(r_sx), .i_sy(r_sy), .i_r(r_r),
        .i_pad_x1(iPAD_X1), .i_pad_x2(iPAD_X2), .i_pad_y(iPAD_Y),
        .o_x(w_x), .o_y(w_y), .o_dx(w_dx), .o_dy(w_dy), .o_hit(w_hit), .o_miss(w_miss)
    );

    // State register together with the registered state-derived outputs.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state  <= ST_IDLE;
            r_ostate <= OST_IDLE;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ostate <= w_ostate_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = iSTART ? ST_RUN : ST_IDLE;
            ST_RUN:   w_state_nxt = iFRAME ? ST_UPD : ST_RUN;
            ST_UPD:   w_state_nxt = w_last ? ST_CHECK : ST_UPD;
            ST_CHECK: begin
                if (r_act != '0) begin
                    w_state_nxt = ST_RUN;
                end else if (r_lives <= 3'd1) begin
                    w_state_nxt = ST_OVER;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_OVER:  w_state_nxt = iSTART ? ST_IDLE : ST_OVER;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Externally visible state: UPD and CHECK report as RUN.
    always_comb begin
        w_busy_nxt = (w_state_nxt == ST_UPD) || (w_state_nxt == ST_CHECK);
        case (w_state_nxt)
            ST_IDLE: w_ostate_nxt = OST_IDLE;
            ST_OVER: w_ostate_nxt = OST_OVER;
            default: w_ostate_nxt = OST_RUN;
        endcase
    end

    // Ball position/direction/alive arrays.
    always_ff @(posedge iCLK) begin
        if (iRST || w_serve) begin
            r_x   <= w_serve_x;
            r_dx  <= w_serve_dx;
            r_dy  <= {N_BALL{DIR_Y_DOWN}};
            r_act <= iRST ? {N_BALL{1'b0}} : {N_BALL{1'b1}};
            for (int i = 0; i < N_BALL; i++) begin
                r_y[i] <= POS_W'(V_ACT / 4);
            end
        end else if (w_upd_act) begin
            r_x[r_idx]   <= w_x;
            r_y[r_idx]   <= w_y;
            r_dx[r_idx]  <= w_dx;
            r_dy[r_idx]  <= w_dy;
            r_act[r_idx] <= ~w_miss;
        end
    end

    // Frame parameters latch, ball index, score, lives and event pulses.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_idx   <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_r     <= '0;
            r_score <= 16'd0;
            r_lives <= 3'(LIVES);
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
        end else begin
            r_hit  <= w_upd_act & w_hit;
            r_miss <= w_upd_act & w_miss;
            case (r_state)
                ST_IDLE: begin
                    if (iSTART) begin
                        r_score <= 16'd0;
                        r_lives <= 3'(LIVES);
                    end
                end
                ST_RUN: begin
                    if (iFRAME) begin
                        r_sx  <= iSPEED_X;
                        r_sy  <= iSPEED_Y;
                        r_r   <= iRADIUS;
                        r_idx <= '0;
                    end
                end
                ST_UPD: begin
                    if (w_upd_act && w_hit && (r_score != 16'hFFFF)) begin
                        r_score <= r_score + 16'd1;
                    end
                    if (!w_last) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (r_act == '0) begin
                        r_lives <= r_lives - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oBALL_ACT = r_act;
    assign oSTATE    = r_ostate;
    assign oSCORE    = r_score;
    assign oLIVES    = r_lives;
    assign oHIT      = r_hit;
    assign oMISS     = r_miss;
    assign oBUSY     = r_busy;

endmodule
